// File: rtl/ibex_register_file_mp_if.sv
// Register file access bundle: read/write ports, clear handshake, parity flags.
// The core side drives addresses, write data and clear requests (master);
// the register file returns read data and status (slave).
interface ibex_register_file_mp_if #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumReadPorts  = 2,
    parameter int unsigned NumWritePorts = 2
);
    logic                                 dummy_instr_id_i;
    logic [NumReadPorts*5-1:0]            raddr_i;
    logic [NumReadPorts*DataWidth-1:0]    rdata_o;
    logic [NumWritePorts*5-1:0]           waddr_i;
    logic [NumWritePorts*DataWidth-1:0]   wdata_i;
    logic [NumWritePorts-1:0]             we_i;
    logic                                 clear_req_i;
    logic                                 clear_busy_o;
    logic                                 clear_done_o;
    logic [NumReadPorts-1:0]              parity_err_o;

    modport master (
        output dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
        input  rdata_o, clear_busy_o, clear_done_o, parity_err_o
    );

    modport slave (
        input  dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
        output rdata_o, clear_busy_o, clear_done_o, parity_err_o
    );
endinterface

// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file for Ibex (ID/WB stages).
// Fixed-priority writes (highest port wins), optional write-to-read bypass,
// sequential zero-clear engine, dummy-instruction R0.
// Optional per-word even parity: define IBEX_RF_PARITY_EN.

// One read lane: picks zero, bypass data or stored word, and checks parity.
module ibex_rf_rd_port #(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0] word,
`ifdef IBEX_RF_PARITY_EN
    input  logic                 stored_par,
`endif
    input  logic                 zero,
    input  logic                 byp_hit,
    input  logic [DataWidth-1:0] byp_data,
    output logic [DataWidth-1:0] rdata,
    output logic                 perr
);
    assign rdata = zero ? '0 : (byp_hit ? byp_data : word);
`ifdef IBEX_RF_PARITY_EN
    // Only words coming out of storage can carry a parity fault.
    assign perr  = ~zero & ~byp_hit & (stored_par ^ (^word));
`else
    assign perr  = 1'b0;
`endif
endmodule

module ibex_register_file_mp #(
    parameter bit          RV32E             = 1'b0,
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned NumReadPorts      = 2,
    parameter int unsigned NumWritePorts     = 2,
    parameter bit          WrBypass          = 1'b1,
    parameter bit          DummyInstructions = 1'b0
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    ibex_register_file_mp_if.slave rf
);
    localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
    localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;
    // With a real R0 the clear sweep starts at word 0, otherwise at word 1.
    localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = DummyInstructions ? '0 : ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [NUM_WORDS-1:0][DataWidth-1:0]      mem_q;
    logic [NUM_WORDS-1:0][DataWidth-1:0]      wr_data;
    logic [NUM_WORDS-1:0]                     wr_en;
    logic [0:0]                               state_q;
    logic [ADDR_WIDTH-1:0]                    clr_idx_q;
    logic                                     busy;
    logic                                     r0_live;
    logic [NumWritePorts-1:0][ADDR_WIDTH-1:0] waddr;
    logic [NumWritePorts-1:0]                 wvld;
    logic [NumReadPorts-1:0][DataWidth-1:0]   rdata;
    logic [NumReadPorts-1:0]                  perr;

    assign busy    = (state_q == ST_CLEAR);
    // R0 behaves as a real register only for dummy instructions.
    assign r0_live = DummyInstructions && rf.dummy_instr_id_i;

    // A write port is effective when enabled, not stalled by a clear, and not
    // aimed at a hardwired-zero R0. Upper address bits are dropped here.
    for (genvar w = 0; w < NumWritePorts; w++) begin : g_wr
        assign waddr[w] = rf.waddr_i[5*w +: ADDR_WIDTH];
        assign wvld[w]  = rf.we_i[w] & ~busy & ((waddr[w] != '0) | r0_live);
    end

    // Per-word write decode; later ports override earlier ones.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            for (int w = 0; w < NumWritePorts; w++) begin
                if (wvld[w] && (waddr[w] == ADDR_WIDTH'(i))) begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = rf.wdata_i[w*DataWidth +: DataWidth];
                end
            end
        end
    end

    // Storage: clear sweep owns the array while busy, otherwise port writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (busy) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (wr_en[i]) mem_q[i] <= wr_data[i];
            end
        end
    end

`ifdef IBEX_RF_PARITY_EN
    logic [NUM_WORDS-1:0] par_q;

    // Even parity tracks its word; cleared words hold parity 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= '0;
        end else if (busy) begin
            par_q[clr_idx_q] <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (wr_en[i]) par_q[i] <= ^wr_data[i];
            end
        end
    end
`endif

    // Clear engine: IDLE waits for a request, CLEAR walks one word per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= IDX_FIRST;
        end else if (state_q == ST_IDLE) begin
            if (rf.clear_req_i) state_q <= ST_CLEAR;
        end else if (clr_idx_q == IDX_LAST) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= IDX_FIRST;
        end else begin
            clr_idx_q <= clr_idx_q + ADDR_WIDTH'(1);
        end
    end

    assign rf.clear_busy_o = busy;
    assign rf.clear_done_o = busy && (clr_idx_q == IDX_LAST);

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr;
        logic                  zero;
        logic                  byp_hit;
        logic [DataWidth-1:0]  byp_data;

        assign raddr = rf.raddr_i[5*p +: ADDR_WIDTH];
        assign zero  = (raddr == '0) && !r0_live;

        // Forward same-cycle write data; highest matching port wins. wvld
        // already excludes busy cycles and non-dummy R0.
        always_comb begin
            byp_hit  = 1'b0;
            byp_data = '0;
            for (int w = 0; w < NumWritePorts; w++) begin
                if (WrBypass && wvld[w] && (waddr[w] == raddr)) begin
                    byp_hit  = 1'b1;
                    byp_data = rf.wdata_i[w*DataWidth +: DataWidth];
                end
            end
        end

        ibex_rf_rd_port #(.DataWidth(DataWidth)) u_rd (
            .word       (mem_q[raddr]),
`ifdef IBEX_RF_PARITY_EN
            .stored_par (par_q[raddr]),
`endif
            .zero       (zero),
            .byp_hit    (byp_hit),
            .byp_data   (byp_data),
            .rdata      (rdata[p]),
            .perr       (perr[p])
        );
    end

    assign rf.rdata_o      = rdata;
    assign rf.parity_err_o = perr;
endmodule
